// File: rtl/optflow_pkg.sv
// Shared types and default frame geometry for the optical-flow read sequencer.
package optflow_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int DEF_WIDTH        = 320;
    localparam int DEF_HEIGHT       = 240;
    localparam int DEF_DRAIN_CYCLES = 660;

endpackage

// File: rtl/gradient_frame_sequencer.sv
// Walks both frame memories in raster order for one frame pair, waits for the
// gradient pipeline to flush, then swaps the current/previous bank.
module gradient_frame_sequencer
    import optflow_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int ADDR_W       = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              grad_valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              bank_curr,
    output logic              pixel_valid,
    output logic              first_frame,
    output logic              busy,
    output logic              frame_done,
    output logic              start_err,
    output logic [15:0]       frame_count,
    output logic [ADDR_W:0]   grad_count
);

    localparam int                PIXELS    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    // Drain counter runs 0..DRAIN_CYCLES-1; DRAIN_CYCLES is expected to be >= 1.
    localparam int                DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    seq_state_t         state;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [ADDR_W-1:0]  addr_last;
    logic [DRAIN_W-1:0] drain_cnt;

    // Read issue reacts to stall in the same cycle so no pixel slot is wasted.
    assign rd_en      = (state == STREAM) && !stall;
    assign rd_addr    = rd_en ? addr_cnt : addr_last;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            addr_last   <= '0;
            drain_cnt   <= '0;
            bank_curr   <= 1'b0;
            pixel_valid <= 1'b0;
            first_frame <= 1'b1;
            start_err   <= 1'b0;
            frame_count <= '0;
            grad_count  <= '0;
        end else begin
            // Memory data arrives one cycle after the read strobe.
            pixel_valid <= rd_en;
            start_err   <= start && (state != IDLE);

            if (busy && grad_valid && !(&grad_count))
                grad_count <= grad_count + 1'b1;

            if (rd_en) begin
                addr_last <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= STREAM;
                        addr_cnt   <= '0;
                        grad_count <= '0;
                    end
                end
                STREAM: begin
                    if (rd_en && (addr_cnt == LAST_ADDR)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        // Bank swap and bookkeeping become visible together with frame_done.
                        state       <= DONE;
                        bank_curr   <= ~bank_curr;
                        frame_count <= frame_count + 16'd1;
                        first_frame <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gradient_frame_sequencer.md
GRADIENT_FRAME_SEQUENCER -- requirements
Module: gradient_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 320: pixels per line.
REQ-002 Parameter HEIGHT, default 240: lines per frame.
REQ-003 Parameter DRAIN_CYCLES, default 660: cycles waited after the last read for gradient pipeline flush.
REQ-004 Parameter ADDR_W, default $clog2(WIDTH*HEIGHT): frame memory address width.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to sequence one frame pair.
REQ-008 stall  in  1  suppress read issue this cycle.
REQ-009 grad_valid  in  1  gradient stage output strobe, counted.
REQ-010 rd_en  out  1  read strobe to both frame memories.
REQ-011 rd_addr  out  ADDR_W  linear pixel address, row*WIDTH+col.
REQ-012 bank_curr  out  1  bank holding the current frame; previous frame is ~bank_curr; writer targets ~bank_curr after each swap.
REQ-013 pixel_valid  out  1  drives gradient stage pixel_valid, aligned with memory data.
REQ-014 first_frame  out  1  high while sequencing the first frame after reset (no valid previous frame).
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 frame_done  out  1  single-cycle completion pulse.
REQ-017 start_err  out  1  single-cycle pulse when start arrives while busy.
REQ-018 frame_count  out  16  completed frames, wraps at 2^16.
REQ-019 grad_count  out  ADDR_W+1  grad_valid strobes seen in the current/last frame.

Function
REQ-020 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-021 IDLE: start=1 SHALL move to STREAM next cycle, clear the address counter to 0 and grad_count to 0.
REQ-022 STREAM: each cycle with stall=0, rd_en=1, rd_addr=counter, counter increments; with stall=1, rd_en=0, counter holds.
REQ-023 STREAM: issuing address WIDTH*HEIGHT-1 SHALL move to DRAIN next cycle with drain counter 0.
REQ-024 pixel_valid SHALL equal rd_en delayed exactly one cycle (1-cycle memory read latency).
REQ-025 DRAIN: rd_en=0, stall ignored; after DRAIN_CYCLES cycles SHALL move to DONE.
REQ-026 DONE lasts one cycle: frame_done=1, bank_curr toggles, frame_count increments, first_frame clears; next state IDLE.
REQ-027 start in IDLE and DONE: DONE ignores start (it is not latched); the requester re-asserts start in IDLE.
REQ-028 start while in STREAM, DRAIN or DONE SHALL be ignored and pulse start_err the next cycle.
REQ-029 grad_count SHALL increment on every grad_valid=1 while busy, saturating at 2^(ADDR_W+1)-1; it holds in IDLE.
REQ-030 rd_addr SHALL hold its last value when rd_en=0.
REQ-031 Total rd_en pulses per frame SHALL equal WIDTH*HEIGHT regardless of stall pattern.

Reset
REQ-032 rst SHALL force IDLE and set every output to 0: rd_en, rd_addr, bank_curr, pixel_valid, busy, frame_done, start_err, frame_count and grad_count.
REQ-033 rst SHALL set first_frame=1.
REQ-034 rst mid-frame SHALL abort immediately, with no frame_done and no bank swap.

Structure
REQ-035 Shared package optflow_pkg SHALL hold the FSM state enum and the default frame dimensions.
REQ-036 The design SHALL be a single module with no sub-modules; the drain counter is inline.

Verification (WIDTH=8, HEIGHT=4, DRAIN_CYCLES=5)
REQ-037 start pulse, stall=0 -> rd_addr 0..31 on 32 consecutive cycles, pixel_valid lags one cycle, frame_done 38 cycles after the start-accept cycle, bank_curr 0->1, frame_count=1, first_frame 1->0.
REQ-038 stall high on every odd cycle of STREAM -> exactly 32 rd_en pulses, addresses contiguous, no skipped or repeated address.
REQ-039 start re-pulsed in STREAM and DRAIN -> start_err pulses each time, frame timing unchanged, only one frame_done.
REQ-040 rst asserted at address 15 -> next cycle all outputs 0, bank_curr=0, first_frame=1; a new start begins at address 0.
REQ-041 Three back-to-back frames -> bank_curr sequence 1,0,1, frame_count 3, first_frame high only during frame 1.
REQ-042 Drive 20 grad_valid pulses during a frame -> grad_count=20 after frame_done, cleared to 0 on next start accept.
